// File: rtl/polar_pkg.sv
// Shared constants, request/lane types and saturating LLR helpers for the polar SIMD unit.
package polar_pkg;

    localparam int XLEN          = 64;
    localparam int QTF_SIZE      = 8;
    localparam int LANES         = XLEN / QTF_SIZE;
    localparam int TRANS_ID_BITS = 3;

    typedef logic signed [QTF_SIZE-1:0] llr_t;

    localparam llr_t MAXV = {1'b0, {(QTF_SIZE-1){1'b1}}};
    localparam llr_t MINV = {1'b1, {(QTF_SIZE-1){1'b0}}};
    localparam logic signed [QTF_SIZE:0] MAXV_W = {2'b00, {(QTF_SIZE-1){1'b1}}};

    typedef enum logic [1:0] {
        PL_F   = 2'd0,
        PL_G   = 2'd1,
        PL_R   = 2'd2,
        PL_NOP = 2'd3
    } polar_op_e;

    typedef struct packed {
        polar_op_e                op;
        logic [XLEN-1:0]          a;
        logic [XLEN-1:0]          b;
        logic [LANES-1:0]         psum;
        logic [LANES-1:0]         frozen;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } polar_req_t;

    // Per-lane values captured in S1; S2 only selects and signs them.
    typedef struct packed {
        logic sgn;
        llr_t mag;
        llr_t gsum;
        llr_t gdif;
        logic neg;
    } lane_s1_t;

    // Symmetric clamp: the most negative code is never produced.
    function automatic llr_t sat_llr(input logic signed [QTF_SIZE:0] x);
        if (x > MAXV_W) begin
            return MAXV;
        end else if (x < -MAXV_W) begin
            return -MAXV;
        end
        return llr_t'(x[QTF_SIZE-1:0]);
    endfunction

    function automatic llr_t abs_sat(input llr_t x);
        if (x == MINV) begin
            return MAXV;
        end else if (x < 0) begin
            return -x;
        end
        return x;
    endfunction

endpackage

// File: rtl/polar_simd_unit_if.sv
// Request/response handshake bundle of the polar SIMD unit; slave is the unit side.
interface polar_simd_unit_if;
    import polar_pkg::*;

    logic                     valid_i;
    logic                     ready_o;
    polar_op_e                op_i;
    logic [XLEN-1:0]          operand_a_i;
    logic [XLEN-1:0]          operand_b_i;
    logic [LANES-1:0]         psum_i;
    logic [LANES-1:0]         frozen_i;
    logic [TRANS_ID_BITS-1:0] trans_id_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [XLEN-1:0]          result_o;
    logic [TRANS_ID_BITS-1:0] trans_id_o;

    modport slave (
        input  valid_i, op_i, operand_a_i, operand_b_i, psum_i, frozen_i, trans_id_i, ready_i,
        output ready_o, valid_o, result_o, trans_id_o
    );

    modport master (
        output valid_i, op_i, operand_a_i, operand_b_i, psum_i, frozen_i, trans_id_i, ready_i,
        input  ready_o, valid_o, result_o, trans_id_o
    );

endinterface

// File: rtl/polar_lane.sv
// Combinational per-lane F/G/R datapath: front half feeds S1, back half feeds S2.
// POLAR_SCALED_MINSUM_EN selects 0.75-scaled min-sum magnitude for F.
module polar_lane
    import polar_pkg::*;
(
    input  llr_t      a_i,
    input  llr_t      b_i,
    output lane_s1_t  pre_o,
    input  polar_op_e op_i,
    input  logic      psum_i,
    input  logic      frozen_i,
    input  lane_s1_t  pre_i,
    output llr_t      res_o,
    output logic      rbit_o
);

    llr_t                      abs_a;
    llr_t                      abs_b;
    logic signed [QTF_SIZE:0]  sum_w;
    logic signed [QTF_SIZE:0]  dif_w;
    llr_t                      mag;

    // ---- S1 input side ----
    always_comb begin
        abs_a      = abs_sat(a_i);
        abs_b      = abs_sat(b_i);
        sum_w      = {b_i[QTF_SIZE-1], b_i} + {a_i[QTF_SIZE-1], a_i};
        dif_w      = {b_i[QTF_SIZE-1], b_i} - {a_i[QTF_SIZE-1], a_i};
        pre_o.sgn  = a_i[QTF_SIZE-1] ^ b_i[QTF_SIZE-1];
        pre_o.mag  = (abs_a < abs_b) ? abs_a : abs_b;
        pre_o.gsum = sat_llr(sum_w);
        pre_o.gdif = sat_llr(dif_w);
        pre_o.neg  = a_i[QTF_SIZE-1];
    end

    // ---- S2 input side ----
    always_comb begin
`ifdef POLAR_SCALED_MINSUM_EN
        mag = pre_i.mag - (pre_i.mag >>> 2);
`else
        mag = pre_i.mag;
`endif
        case (op_i)
            PL_F:    res_o = pre_i.sgn ? -mag : mag;
            PL_G:    res_o = psum_i ? pre_i.gdif : pre_i.gsum;
            default: res_o = '0;
        endcase
        rbit_o = !frozen_i && pre_i.neg;
    end

endmodule

// File: rtl/polar_simd_unit.sv
// Two-stage multi-lane polar SC kernel unit (F/G/R/NOP) behind a valid/ready handshake.
// POLAR_SCALED_MINSUM_EN (see polar_lane) enables scaled min-sum for F.
module polar_simd_unit
    import polar_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    polar_simd_unit_if.slave  bus,
    output logic              busy_o
);

    polar_req_t               req;
    lane_s1_t [LANES-1:0]     pre_w;
    lane_s1_t [LANES-1:0]     pre_q;
    logic [XLEN-1:0]          res_w;
    logic [LANES-1:0]         rbit_w;

    polar_op_e                op_q;
    logic [LANES-1:0]         psum_q;
    logic [LANES-1:0]         frozen_q;
    logic [TRANS_ID_BITS-1:0] tid1_q;
    logic                     s1_valid_q, s1_valid_d;

    logic [XLEN-1:0]          result_q, result_d;
    logic [TRANS_ID_BITS-1:0] tid2_q;
    logic                     s2_valid_q, s2_valid_d;

    logic                     s1_load;
    logic                     s2_load;
    logic                     accept;

    always_comb begin
        req.op       = bus.op_i;
        req.a        = bus.operand_a_i;
        req.b        = bus.operand_b_i;
        req.psum     = bus.psum_i;
        req.frozen   = bus.frozen_i;
        req.trans_id = bus.trans_id_i;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        polar_lane u_lane (
            .a_i      (req.a[i*QTF_SIZE +: QTF_SIZE]),
            .b_i      (req.b[i*QTF_SIZE +: QTF_SIZE]),
            .pre_o    (pre_w[i]),
            .op_i     (op_q),
            .psum_i   (psum_q[i]),
            .frozen_i (frozen_q[i]),
            .pre_i    (pre_q[i]),
            .res_o    (res_w[i*QTF_SIZE +: QTF_SIZE]),
            .rbit_o   (rbit_w[i])
        );
    end

    // Ready depends only on pipeline state and ready_i, never on valid_i.
    always_comb begin
        s2_load    = !s2_valid_q || bus.ready_i;
        s1_load    = !s1_valid_q || s2_load;
        accept     = bus.valid_i && s1_load;

        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s1_load) s1_valid_d = accept;
            if (s2_load) s2_valid_d = s1_valid_q;
        end

        case (op_q)
            PL_F, PL_G: result_d = res_w;
            PL_R:       result_d = {{(XLEN-LANES){1'b0}}, rbit_w};
            default:    result_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            tid2_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            // ---- S1 -> S2 ----
            if (s2_load && s1_valid_q) begin
                result_q <= result_d;
                tid2_q   <= tid1_q;
            end
        end
    end

    // ---- input -> S1 ---- (datapath only; qualified by s1_valid_q)
    always_ff @(posedge clk_i) begin
        if (accept) begin
            pre_q    <= pre_w;
            op_q     <= req.op;
            psum_q   <= req.psum;
            frozen_q <= req.frozen;
            tid1_q   <= req.trans_id;
        end
    end

    assign bus.ready_o    = s1_load;
    assign bus.valid_o    = s2_valid_q;
    assign bus.result_o   = result_q;
    assign bus.trans_id_o = tid2_q;
    assign busy_o         = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_polar_simd_unit.sv
// Testbench for polar_simd_unit: directed vector table, multi-cycle handshake sequences
// and a randomized run scored against an arithmetic reference model.
module tb_polar_simd_unit;
    import polar_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic busy;

    polar_simd_unit_if ifc();

    polar_simd_unit dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (ifc.slave),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    bit last_acc = 1'b0;
    bit use_sb   = 1'b0;

    typedef struct {
        logic [XLEN-1:0]          res;
        logic [TRANS_ID_BITS-1:0] tid;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        string                    name;
        polar_op_e                op;
        logic [XLEN-1:0]          a;
        logic [XLEN-1:0]          b;
        logic [LANES-1:0]         u;
        logic [LANES-1:0]         fz;
        logic [TRANS_ID_BITS-1:0] tid;
        logic [XLEN-1:0]          exp;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: lane arithmetic straight from the kernel definitions, using plain integers.
    function automatic logic [XLEN-1:0] model(input polar_op_e op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b, input logic [LANES-1:0] u,
                                              input logic [LANES-1:0] fz);
        logic [XLEN-1:0] r;
        int maxv;
        r    = '0;
        maxv = 2 ** (QTF_SIZE - 1) - 1;
        for (int i = 0; i < LANES; i++) begin
            int av, bv, am, bm, m, x;
            av = int'($signed(a[i*QTF_SIZE +: QTF_SIZE]));
            bv = int'($signed(b[i*QTF_SIZE +: QTF_SIZE]));
            case (op)
                PL_F: begin
                    am = (av < 0) ? -av : av;
                    bm = (bv < 0) ? -bv : bv;
                    if (am > maxv) am = maxv;
                    if (bm > maxv) bm = maxv;
                    m = (am < bm) ? am : bm;
`ifdef POLAR_SCALED_MINSUM_EN
                    m = m - m / 4;
`endif
                    x = ((av < 0) != (bv < 0)) ? -m : m;
                    r[i*QTF_SIZE +: QTF_SIZE] = x[QTF_SIZE-1:0];
                end
                PL_G: begin
                    x = u[i] ? (bv - av) : (bv + av);
                    if (x > maxv) x = maxv;
                    if (x < -maxv) x = -maxv;
                    r[i*QTF_SIZE +: QTF_SIZE] = x[QTF_SIZE-1:0];
                end
                PL_R: r[i] = !fz[i] && (av < 0);
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic drive(input bit v, input polar_op_e op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [LANES-1:0] u,
                         input logic [LANES-1:0] fz, input logic [TRANS_ID_BITS-1:0] tid);
        ifc.valid_i     = v;
        ifc.op_i        = op;
        ifc.operand_a_i = a;
        ifc.operand_b_i = b;
        ifc.psum_i      = u;
        ifc.frozen_i    = fz;
        ifc.trans_id_i  = tid;
    endtask

    task automatic drive_rand(input bit v);
        drive(v, polar_op_e'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
              LANES'($urandom), LANES'($urandom), TRANS_ID_BITS'($urandom));
    endtask

    // Called at a falling edge with inputs set; scores the transfers of the next rising edge.
    task automatic tick();
        exp_t e;
        #1;
        last_acc = ifc.valid_i && ifc.ready_o;
        if (use_sb && ifc.valid_o && ifc.ready_i) begin
            n_out++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got result %h tid %0d, expected no output",
                         ifc.result_o, ifc.trans_id_o);
            end else begin
                e = sbq.pop_front();
                chk("sb_result", ifc.result_o, e.res);
                chk("sb_tid", 64'(ifc.trans_id_o), 64'(e.tid));
            end
        end
        if (use_sb) begin
            if (flush) begin
                sbq.delete();
            end else if (last_acc) begin
                e.res = model(ifc.op_i, ifc.operand_a_i, ifc.operand_b_i, ifc.psum_i, ifc.frozen_i);
                e.tid = ifc.trans_id_i;
                sbq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        use_sb      = 1'b0;
        ifc.ready_i = 1'b1;
        drive(1'b1, v.op, v.a, v.b, v.u, v.fz, v.tid);
        tick();
        chk({v.name, "_accept"}, 64'(last_acc), 64'd1);
        ifc.valid_i = 1'b0;
        cyc = 1;
        while (!ifc.valid_o && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk({v.name, "_latency"}, 64'(cyc), 64'd2);
        chk({v.name, "_result"}, ifc.result_o, v.exp);
        chk({v.name, "_tid"}, 64'(ifc.trans_id_o), 64'(v.tid));
        tick();
        chk({v.name, "_drained"}, 64'(ifc.valid_o), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [XLEN-1:0]          bp_a[4];
        logic [XLEN-1:0]          bp_b[4];
        polar_op_e                bp_op[4];
        logic [LANES-1:0]         bp_u[4];
        logic [XLEN-1:0]          first_exp;
        vec_t                     fresh;
        int                       sent;
        int                       vcount;

        drive(1'b0, PL_NOP, '0, '0, '0, '0, '0);
        ifc.ready_i = 1'b0;

        // ---- reset ----
        #1 rst = 1'b1;
        #2;
        chk("rst_valid_o", 64'(ifc.valid_o), 64'd0);
        chk("rst_result_o", ifc.result_o, 64'd0);
        chk("rst_trans_id_o", 64'(ifc.trans_id_o), 64'd0);
        chk("rst_busy_o", 64'(busy), 64'd0);
        chk("rst_ready_o", 64'(ifc.ready_o), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---- directed vector table ----
        vt.push_back('{"f_basic", PL_F, 64'h05, 64'hFD, 8'h00, 8'h00, 3'd5, 64'hFD});
`ifdef POLAR_SCALED_MINSUM_EN
        vt.push_back('{"f_small", PL_F, 64'h0401, 64'hFA01, 8'h00, 8'h00, 3'd1, 64'hFD01});
        vt.push_back('{"f_minneg", PL_F, 64'h8080, 64'h0580, 8'h00, 8'h00, 3'd2, 64'hFC60});
`else
        vt.push_back('{"f_small", PL_F, 64'h0401, 64'hFA01, 8'h00, 8'h00, 3'd1, 64'hFC01});
        vt.push_back('{"f_minneg", PL_F, 64'h8080, 64'h0580, 8'h00, 8'h00, 3'd2, 64'hFB7F});
`endif
        vt.push_back('{"g_sat", PL_G, 64'h05909070, 64'h03808070, 8'h0A, 8'h00, 3'd3,
                       64'hFE81F07F});
        vt.push_back('{"g_lanes", PL_G, 64'h0807060504030201, 64'h1010101010101010, 8'hAA, 8'h00,
                       3'd4, 64'h08170A150C130E11});
        vt.push_back('{"g_edge", PL_G, 64'h817F, 64'h7F81, 8'h03, 8'h00, 3'd6, 64'h7F81});
        vt.push_back('{"r_mask", PL_R, 64'h01FE038000F905FF, 64'h123456789ABCDEF0, 8'h00, 8'h04,
                       3'd0, 64'h51});
        vt.push_back('{"nop", PL_NOP, 64'hFFFFFFFFFFFFFFFF, 64'h123456789ABCDEF0, 8'hFF, 8'hFF,
                       3'd7, 64'h0});
        foreach (vt[k]) run_vec(vt[k]);

        // ---- backpressure: four back-to-back requests against a stalled consumer ----
        for (int k = 0; k < 4; k++) begin
            bp_op[k] = (k % 2 == 0) ? PL_F : PL_G;
            bp_a[k]  = {$urandom, $urandom};
            bp_b[k]  = {$urandom, $urandom};
            bp_u[k]  = LANES'($urandom);
        end
        first_exp   = model(bp_op[0], bp_a[0], bp_b[0], bp_u[0], '0);
        use_sb      = 1'b1;
        n_out       = 0;
        sbq.delete();
        ifc.ready_i = 1'b0;
        sent        = 0;
        for (int c = 0; c < 6; c++) begin
            if (sent < 4) drive(1'b1, bp_op[sent], bp_a[sent], bp_b[sent], bp_u[sent], '0,
                                TRANS_ID_BITS'(sent + 4));
            tick();
            if (last_acc) sent++;
            if (c >= 1) begin
                chk("bp_hold_valid", 64'(ifc.valid_o), 64'd1);
                chk("bp_hold_result", ifc.result_o, first_exp);
                chk("bp_ready_low", 64'(ifc.ready_o), 64'd0);
            end
        end
        chk("bp_accepts_stalled", 64'(sent), 64'd2);
        ifc.ready_i = 1'b1;
        for (int c = 0; c < 30 && !(sent == 4 && n_out == 4); c++) begin
            if (sent < 4) drive(1'b1, bp_op[sent], bp_a[sent], bp_b[sent], bp_u[sent], '0,
                                TRANS_ID_BITS'(sent + 4));
            else ifc.valid_i = 1'b0;
            tick();
            if (last_acc) sent++;
        end
        ifc.valid_i = 1'b0;
        tick();
        chk("bp_delivered", 64'(n_out), 64'd4);
        chk("bp_queue_empty", 64'(sbq.size()), 64'd0);

        // ---- flush with S1 and S2 full plus a request in the same cycle ----
        ifc.ready_i = 1'b0;
        n_out = 0;
        drive_rand(1'b1);
        tick();
        drive_rand(1'b1);
        tick();
        chk("fl_busy_full", 64'(busy), 64'd1);
        drive_rand(1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ifc.valid_i = 1'b0;
        chk("fl_valid_o", 64'(ifc.valid_o), 64'd0);
        chk("fl_busy", 64'(busy), 64'd0);
        ifc.ready_i = 1'b1;
        vcount = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ifc.valid_o) vcount++;
        end
        chk("fl_no_output", 64'(vcount + n_out), 64'd0);

        // flush on an empty pipeline: the offered request is taken and dropped
        drive_rand(1'b1);
        flush = 1'b1;
        tick();
        chk("fl_accept", 64'(last_acc), 64'd1);
        flush = 1'b0;
        ifc.valid_i = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("fl_empty_no_output", 64'(n_out), 64'd0);
        fresh = '{"fl_after", PL_F, 64'h05, 64'hFD, 8'h00, 8'h00, 3'd2, 64'hFD};
        run_vec(fresh);

        // ---- asynchronous reset between clock edges ----
        ifc.ready_i = 1'b1;
        drive_rand(1'b1);
        tick();
        drive_rand(1'b1);
        tick();
        ifc.valid_i = 1'b0;
        chk("ar_busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid_o", 64'(ifc.valid_o), 64'd0);
        chk("ar_busy_o", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        chk("ar_ready_o", 64'(ifc.ready_o), 64'd1);
        fresh = '{"ar_after", PL_F, 64'hFB80, 64'h0A7F, 8'h00, 8'h00, 3'd3, 64'h0};
        fresh.exp = model(PL_F, fresh.a, fresh.b, '0, '0);
        run_vec(fresh);

        // ---- randomized traffic with stalls and occasional flushes ----
        use_sb = 1'b1;
        n_out  = 0;
        sbq.delete();
        for (int c = 0; c < 600; c++) begin
            drive_rand($urandom_range(0, 9) < 7);
            ifc.ready_i = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 49) == 0);
            tick();
        end
        flush       = 1'b0;
        ifc.valid_i = 1'b0;
        ifc.ready_i = 1'b1;
        for (int c = 0; c < 20 && (sbq.size() != 0 || busy); c++) tick();
        chk("rand_drained", 64'(sbq.size()), 64'd0);
        chk("rand_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
